// File: rtl/bram_sdp_bwe.sv
// Simple-dual-port behavioural RAM with per-byte write enables, 1- or 2-cycle
// registered read, selectable read-during-write behaviour, a zero-clear
// sequencer and a sticky out-of-range flag. Simulation buffer, not for synthesis.
// AW must leave at least $clog2(DEPTH) bits above the byte-offset bits.

module bram_sdp_bwe #(
    parameter int unsigned DW           = 128,
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned AW           = 13,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned RDW_MODE     = 0,
    parameter int unsigned CLEAR_ON_RST = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            wr_en,
    input  logic [DW/8-1:0] wr_be,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   Di,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output logic [DW-1:0]   Do,
    output logic            rd_valid,
    input  logic            clr_req,
    output logic            busy,
    output logic            err
);

    localparam int unsigned NB  = DW / 8;
    localparam int unsigned OFF = (NB > 1) ? $clog2(NB) : 0;
    localparam int unsigned IW  = AW - OFF;
    localparam int unsigned MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [IW:0]   DEPTH_W = (IW + 1)'(DEPTH);
    localparam logic [MW-1:0] LAST    = MW'(DEPTH - 1);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e          state_q;
    logic [MW-1:0]   clr_idx_q;

    logic [DW-1:0]   mem [DEPTH];

    logic [IW-1:0]   wr_idx;
    logic [IW-1:0]   rd_idx;
    logic [MW-1:0]   wr_ptr;
    logic [MW-1:0]   rd_ptr;
    logic            wr_in_range;
    logic            rd_in_range;
    logic            idle;
    logic            wr_fire;
    logic            rd_take;
    logic            flush;
    logic [DW-1:0]   rd_word;

    logic            v1_q;
    logic [DW-1:0]   d1_q;

    // Word index is the byte address with the in-word offset dropped.
    assign wr_idx      = wr_addr[AW-1:OFF];
    assign rd_idx      = rd_addr[AW-1:OFF];
    assign wr_ptr      = wr_idx[MW-1:0];
    assign rd_ptr      = rd_idx[MW-1:0];
    assign wr_in_range = {1'b0, wr_idx} < DEPTH_W;
    assign rd_in_range = {1'b0, rd_idx} < DEPTH_W;

    assign idle    = (state_q == StIdle);
    assign busy    = (state_q == StClear);
    assign wr_fire = idle && wr_en && wr_in_range;
    // A clear request wins over a read in the same cycle so no valid leaks
    // out while busy is high.
    assign rd_take = idle && rd_en && !clr_req;
    assign flush   = busy || (idle && clr_req);

    generate
        if (OFF > 0) begin : g_unused_offset
            logic unused_offset;
            assign unused_offset = ^{wr_addr[OFF-1:0], rd_addr[OFF-1:0]};
        end
    endgenerate

    // Clear sequencer: IDLE <-> CLEAR, walks clr_idx_q over every word once.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= (CLEAR_ON_RST != 0) ? StClear : StIdle;
            clr_idx_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (clr_req) begin
                        state_q   <= StClear;
                        clr_idx_q <= '0;
                    end
                end
                StClear: begin
                    clr_idx_q <= clr_idx_q + MW'(1);
                    if (clr_idx_q == LAST) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    clr_idx_q <= '0;
                end
            endcase
        end
    end

    // Array update: clear writes take the port while busy, else byte-masked writes.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (busy) begin
                mem[clr_idx_q] <= '0;
            end else if (wr_fire) begin
                for (int unsigned b = 0; b < NB; b++) begin
                    if (wr_be[b]) begin
                        mem[wr_ptr][8*b +: 8] <= Di[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read word as seen this cycle, including same-word write forwarding.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_ptr];
        end
        if ((RDW_MODE != 0) && wr_fire && (wr_idx == rd_idx)) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    rd_word[8*b +: 8] = Di[8*b +: 8];
                end
            end
        end
    end

    // First read stage; data only moves on an accepted read so Do holds otherwise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            v1_q <= 1'b0;
            d1_q <= '0;
        end else begin
            v1_q <= rd_take;
            if (rd_take) begin
                d1_q <= rd_word;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic          v2_q;
            logic [DW-1:0] d2_q;

            // Output register; in-flight data is dropped when a clear is running.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    v2_q <= 1'b0;
                    d2_q <= '0;
                end else begin
                    v2_q <= v1_q && !flush;
                    if (v1_q && !flush) begin
                        d2_q <= d1_q;
                    end
                end
            end

            assign Do       = d2_q;
            assign rd_valid = v2_q;
        end else begin : g_lat1
            assign Do       = d1_q;
            assign rd_valid = v1_q;
        end
    endgenerate

    // Sticky out-of-range flag for any request presented while idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err <= 1'b0;
        end else if (idle && ((wr_en && !wr_in_range) || (rd_en && !rd_in_range))) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bram_sdp_bwe.sv
// Directed bench for bram_sdp_bwe. Instance A: DEPTH 8, latency 1, read-first.
// Instance B: DEPTH 200, latency 2, write-first.

module tb_bram_sdp_bwe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic         a_rst, a_wr_en, a_rd_en, a_clr_req, a_rd_valid, a_busy, a_err;
    logic [15:0]  a_wr_be;
    logic [12:0]  a_wr_addr, a_rd_addr;
    logic [127:0] a_di, a_do;

    logic         b_rst, b_wr_en, b_rd_en, b_clr_req, b_rd_valid, b_busy, b_err;
    logic [15:0]  b_wr_be;
    logic [12:0]  b_wr_addr, b_rd_addr;
    logic [127:0] b_di, b_do;

    localparam logic [127:0] PAT = 128'h0F0E0D0C0B0A09080706050403020100;

    bram_sdp_bwe #(
        .DW(128), .DEPTH(8), .AW(13), .RD_LAT(1), .RDW_MODE(0), .CLEAR_ON_RST(1)
    ) u_a (
        .CLK(clk), .RST(a_rst), .wr_en(a_wr_en), .wr_be(a_wr_be), .wr_addr(a_wr_addr),
        .Di(a_di), .rd_en(a_rd_en), .rd_addr(a_rd_addr), .Do(a_do),
        .rd_valid(a_rd_valid), .clr_req(a_clr_req), .busy(a_busy), .err(a_err)
    );

    bram_sdp_bwe #(
        .DW(128), .DEPTH(200), .AW(13), .RD_LAT(2), .RDW_MODE(1), .CLEAR_ON_RST(1)
    ) u_b (
        .CLK(clk), .RST(b_rst), .wr_en(b_wr_en), .wr_be(b_wr_be), .wr_addr(b_wr_addr),
        .Di(b_di), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .Do(b_do),
        .rd_valid(b_rd_valid), .clr_req(b_clr_req), .busy(b_busy), .err(b_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit b, input logic we, input logic [15:0] be,
                         input logic [12:0] wa, input logic [127:0] d,
                         input logic re, input logic [12:0] ra);
        if (!b) begin
            a_wr_en = we; a_wr_be = be; a_wr_addr = wa; a_di = d; a_rd_en = re; a_rd_addr = ra;
        end else begin
            b_wr_en = we; b_wr_be = be; b_wr_addr = wa; b_di = d; b_rd_en = re; b_rd_addr = ra;
        end
    endtask

    task automatic quiet(input bit b);
        drive(b, 1'b0, 16'h0, 13'h0, 128'h0, 1'b0, 13'h0);
    endtask

    function automatic logic busy_of(input bit b);
        return b ? b_busy : a_busy;
    endfunction

    // Counts samples with busy high, starting from the current one.
    task automatic count_busy(input bit b, input int limit, output int n);
        n = 0;
        while (busy_of(b) === 1'b1 && n < limit) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset;
        int n;
        a_rst = 1'b1; b_rst = 1'b1;
        tick();
        checks++;
        if (a_busy !== 1'b1 || a_rd_valid !== 1'b0 || a_err !== 1'b0 || a_do !== 128'h0) begin
            errors++;
            $display("FAIL reset_a: busy=%b valid=%b err=%b do=%h, want 1 0 0 0",
                     a_busy, a_rd_valid, a_err, a_do);
        end
        checks++;
        if (b_busy !== 1'b1 || b_rd_valid !== 1'b0 || b_err !== 1'b0 || b_do !== 128'h0) begin
            errors++;
            $display("FAIL reset_b: busy=%b valid=%b err=%b do=%h, want 1 0 0 0",
                     b_busy, b_rd_valid, b_err, b_do);
        end
        a_rst = 1'b0; b_rst = 1'b0;
        count_busy(1'b0, 50, n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL reset_clear_len_a: busy cycles=%0d, want 8", n);
        end
        // B started on the same edge and has 192 of its 200 busy cycles left.
        count_busy(1'b1, 400, n);
        checks++;
        if (n !== 192) begin
            errors++;
            $display("FAIL reset_clear_len_b: remaining busy cycles=%0d, want 192", n);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 16'h0, 13'h0, 128'h0, 1'b1, 13'(i * 16));
            tick();
            checks++;
            if (a_rd_valid !== 1'b1 || a_do !== 128'h0) begin
                errors++;
                $display("FAIL reset_read_word%0d: valid=%b do=%h, want 1 0", i, a_rd_valid, a_do);
            end
        end
        quiet(1'b0);
        tick();
        checks++;
        if (a_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_read_idle: valid=%b, want 0", a_rd_valid);
        end
    endtask

    task automatic test_byte_merge;
        drive(1'b0, 1'b1, 16'hFFFF, 13'h20, PAT, 1'b0, 13'h0);
        tick();
        drive(1'b0, 1'b1, 16'h00F0, 13'h20, {16{8'hAA}}, 1'b0, 13'h0);
        tick();
        drive(1'b0, 1'b1, 16'h0000, 13'h20, {16{8'h55}}, 1'b0, 13'h0);
        tick();
        drive(1'b0, 1'b0, 16'h0, 13'h0, 128'h0, 1'b1, 13'h20);
        tick();
        checks++;
        if (a_rd_valid !== 1'b1 || a_do !== 128'h0F0E0D0C0B0A0908AAAAAAAA03020100) begin
            errors++;
            $display("FAIL byte_merge: valid=%b do=%h, want 1 0f0e0d0c0b0a0908aaaaaaaa03020100",
                     a_rd_valid, a_do);
        end
        // Low address bits are ignored on both ports.
        drive(1'b0, 1'b1, 16'h8000, 13'h2F, {16{8'h99}}, 1'b0, 13'h0);
        tick();
        drive(1'b0, 1'b0, 16'h0, 13'h0, 128'h0, 1'b1, 13'h2B);
        tick();
        checks++;
        if (a_rd_valid !== 1'b1 || a_do !== 128'h990E0D0C0B0A0908AAAAAAAA03020100) begin
            errors++;
            $display("FAIL byte_top_unaligned: valid=%b do=%h, want 1 990e0d0c0b0a0908aaaaaaaa03020100",
                     a_rd_valid, a_do);
        end
        quiet(1'b0);
        tick();
        checks++;
        if (a_rd_valid !== 1'b0 || a_do !== 128'h990E0D0C0B0A0908AAAAAAAA03020100) begin
            errors++;
            $display("FAIL do_hold: valid=%b do=%h, want 0 with held data", a_rd_valid, a_do);
        end
    endtask

    task automatic test_rdw;
        // A: read-first.
        drive(1'b0, 1'b1, 16'hFFFF, 13'h50, {16{8'h11}}, 1'b0, 13'h0);
        tick();
        drive(1'b0, 1'b1, 16'hFFFF, 13'h50, {16{8'h22}}, 1'b1, 13'h50);
        tick();
        checks++;
        if (a_rd_valid !== 1'b1 || a_do !== {16{8'h11}}) begin
            errors++;
            $display("FAIL rdw_read_first: valid=%b do=%h, want 1 1111..", a_rd_valid, a_do);
        end
        drive(1'b0, 1'b1, 16'hFFFF, 13'h60, {16{8'h33}}, 1'b1, 13'h50);
        tick();
        checks++;
        if (a_rd_valid !== 1'b1 || a_do !== {16{8'h22}}) begin
            errors++;
            $display("FAIL rdw_other_word_a: valid=%b do=%h, want 1 2222..", a_rd_valid, a_do);
        end
        quiet(1'b0);
        tick();
        // B: write-first, two-cycle latency.
        drive(1'b1, 1'b1, 16'hFFFF, 13'h50, {16{8'h11}}, 1'b0, 13'h0);
        tick();
        drive(1'b1, 1'b1, 16'hFFFF, 13'h50, {16{8'h22}}, 1'b1, 13'h50);
        tick();
        quiet(1'b1);
        checks++;
        if (b_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat2_first_edge: valid=%b, want 0", b_rd_valid);
        end
        tick();
        checks++;
        if (b_rd_valid !== 1'b1 || b_do !== {16{8'h22}}) begin
            errors++;
            $display("FAIL rdw_write_first: valid=%b do=%h, want 1 2222..", b_rd_valid, b_do);
        end
        drive(1'b1, 1'b1, 16'h00FF, 13'h50, {16{8'h33}}, 1'b1, 13'h50);
        tick();
        quiet(1'b1);
        tick();
        checks++;
        if (b_rd_valid !== 1'b1 || b_do !== {{8{8'h22}}, {8{8'h33}}}) begin
            errors++;
            $display("FAIL rdw_write_first_partial: valid=%b do=%h, want 1 2222..3333..",
                     b_rd_valid, b_do);
        end
        tick();
        checks++;
        if (b_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rdw_b_drain: valid=%b, want 0", b_rd_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bv;
        for (int i = 0; i < 4; i++) begin
            bv = 8'h40 + 8'(i);
            drive(1'b1, 1'b1, 16'hFFFF, 13'(i * 16), {16{bv}}, 1'b0, 13'h0);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 16'h0, 13'h0, 128'h0, 1'b1, 13'(k * 16));
            tick();
            bv = 8'h40 + 8'(k - 1);
            checks++;
            if (k == 0 && b_rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_edge0: valid=%b, want 0", b_rd_valid);
            end else if (k != 0 && (b_rd_valid !== 1'b1 || b_do !== {16{bv}})) begin
                errors++;
                $display("FAIL b2b_word%0d: valid=%b do=%h, want 1 %h", k - 1, b_rd_valid, b_do, {16{bv}});
            end
        end
        quiet(1'b1);
        tick();
        checks++;
        if (b_rd_valid !== 1'b1 || b_do !== {16{8'h43}}) begin
            errors++;
            $display("FAIL b2b_word3: valid=%b do=%h, want 1 4343..", b_rd_valid, b_do);
        end
        tick();
        checks++;
        if (b_rd_valid !== 1'b0 || b_do !== {16{8'h43}}) begin
            errors++;
            $display("FAIL b2b_end: valid=%b do=%h, want 0 4343..", b_rd_valid, b_do);
        end
    endtask

    task automatic test_out_of_range;
        int n;
        checks++;
        if (b_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_pre: err=%b, want 0", b_err);
        end
        drive(1'b1, 1'b1, 16'hFFFF, 13'd3200, {16{8'hFF}}, 1'b1, 13'd3200);
        tick();
        quiet(1'b1);
        checks++;
        if (b_err !== 1'b1) begin
            errors++;
            $display("FAIL oor_err_set: err=%b, want 1", b_err);
        end
        tick();
        checks++;
        if (b_rd_valid !== 1'b1 || b_do !== 128'h0) begin
            errors++;
            $display("FAIL oor_read: valid=%b do=%h, want 1 0", b_rd_valid, b_do);
        end
        drive(1'b1, 1'b0, 16'h0, 13'h0, 128'h0, 1'b1, 13'h0);
        tick();
        quiet(1'b1);
        tick();
        checks++;
        if (b_rd_valid !== 1'b1 || b_do !== {16{8'h40}} || b_err !== 1'b1) begin
            errors++;
            $display("FAIL oor_word0_kept: valid=%b do=%h err=%b, want 1 4040.. 1",
                     b_rd_valid, b_do, b_err);
        end
        b_rst = 1'b1;
        tick();
        b_rst = 1'b0;
        checks++;
        if (b_err !== 1'b0 || b_busy !== 1'b1) begin
            errors++;
            $display("FAIL oor_rst: err=%b busy=%b, want 0 1", b_err, b_busy);
        end
        count_busy(1'b1, 400, n);
        checks++;
        if (n !== 200) begin
            errors++;
            $display("FAIL clear_len_b: busy cycles=%0d, want 200", n);
        end
        drive(1'b1, 1'b1, 16'hFFFF, 13'd3200, {16{8'hFF}}, 1'b0, 13'h0);
        tick();
        quiet(1'b1);
        checks++;
        if (b_err !== 1'b1) begin
            errors++;
            $display("FAIL oor_write_only: err=%b, want 1", b_err);
        end
    endtask

    task automatic test_clear_block;
        int n;
        a_clr_req = 1'b1;
        tick();
        a_clr_req = 1'b0;
        checks++;
        if (a_busy !== 1'b1) begin
            errors++;
            $display("FAIL clr_req_busy: busy=%b, want 1", a_busy);
        end
        drive(1'b0, 1'b0, 16'h0, 13'h0, 128'h0, 1'b1, 13'h20);
        tick();
        checks++;
        if (a_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_read_1: valid=%b, want 0", a_rd_valid);
        end
        // Word 0 is already cleared here; an accepted write would survive.
        drive(1'b0, 1'b1, 16'hFFFF, 13'h0, {16{8'h77}}, 1'b1, 13'h20);
        tick();
        checks++;
        if (a_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_read_2: valid=%b, want 0", a_rd_valid);
        end
        quiet(1'b0);
        tick();
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        count_busy(1'b0, 50, n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL clear_restart_len: busy cycles=%0d, want 8", n);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 16'h0, 13'h0, 128'h0, 1'b1, 13'(i * 16));
            tick();
            checks++;
            if (a_rd_valid !== 1'b1 || a_do !== 128'h0) begin
                errors++;
                $display("FAIL after_clear_word%0d: valid=%b do=%h, want 1 0", i, a_rd_valid, a_do);
            end
        end
        quiet(1'b0);
        tick();
    endtask

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        a_clr_req = 1'b0; b_clr_req = 1'b0;
        quiet(1'b0);
        quiet(1'b1);
        test_reset();
        test_byte_merge();
        test_rdw();
        test_back_to_back();
        test_out_of_range();
        test_clear_block();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
